// File: rtl/wash_ctrl.sv
// Wash-cycle sequencer: charges programme cost, steps wash/rinse/spin/done on a per-second tick.
// Latency: all outputs registered, valid one edge after the accepting start; no backpressure, start ignored while running.
module wash_ctrl #(
    parameter int CLK_PER_SEC = 100_000_000,
    parameter int DONE_SEC    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic [9:0] bal_in,
    input  logic       pause,
    input  logic       abort,
    output logic [2:0] phase,
    output logic [7:0] remain,
    output logic [9:0] bal_out,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       motor,
    output logic       valve,
    output logic       drain
);

    localparam int PW = (CLK_PER_SEC > 2) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_PER_SEC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WASH  = 3'd1,
        S_RINSE = 3'd2,
        S_SPIN  = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    remain_q, remain_d;
    logic [9:0]    bal_q, bal_d;
    logic [1:0]    mode_q, mode_d;
    logic [PW-1:0] pre_q, pre_d;

    logic active;
    logic counting;
    logic tick;
    logic frz;
    state_t nxt;

    function automatic logic [9:0] cost_of(input logic [1:0] m);
        case (m)
            2'd0:    cost_of = 10'd5;
            2'd1:    cost_of = 10'd10;
            2'd2:    cost_of = 10'd15;
            default: cost_of = 10'd3;
        endcase
    endfunction

    function automatic logic [7:0] dur_of(input state_t s, input logic [1:0] m);
        dur_of = 8'd0;
        case (s)
            S_WASH: begin
                case (m)
                    2'd0:    dur_of = 8'd4;
                    2'd1:    dur_of = 8'd8;
                    2'd2:    dur_of = 8'd12;
                    default: dur_of = 8'd0;
                endcase
            end
            S_RINSE: begin
                case (m)
                    2'd0:    dur_of = 8'd2;
                    2'd1:    dur_of = 8'd4;
                    2'd2:    dur_of = 8'd6;
                    default: dur_of = 8'd0;
                endcase
            end
            S_SPIN: begin
                case (m)
                    2'd0:    dur_of = 8'd2;
                    2'd1:    dur_of = 8'd4;
                    2'd2:    dur_of = 8'd6;
                    default: dur_of = 8'd4;
                endcase
            end
            S_DONE:  dur_of = 8'(DONE_SEC);
            default: dur_of = 8'd0;
        endcase
    endfunction

    // Zero-length phases are skipped in the same edge, so there is never a dead cycle.
    function automatic state_t next_phase(input state_t s, input logic [1:0] m);
        next_phase = S_DONE;
        case (s)
            S_IDLE, S_ERR: begin
                if (dur_of(S_WASH, m) != 8'd0)
                    next_phase = S_WASH;
                else if (dur_of(S_RINSE, m) != 8'd0)
                    next_phase = S_RINSE;
                else
                    next_phase = S_SPIN;
            end
            S_WASH: begin
                if (dur_of(S_RINSE, m) != 8'd0)
                    next_phase = S_RINSE;
                else if (dur_of(S_SPIN, m) != 8'd0)
                    next_phase = S_SPIN;
                else
                    next_phase = S_DONE;
            end
            S_RINSE: begin
                if (dur_of(S_SPIN, m) != 8'd0)
                    next_phase = S_SPIN;
                else
                    next_phase = S_DONE;
            end
            default: next_phase = S_DONE;
        endcase
    endfunction

    assign active   = (state_q == S_WASH) || (state_q == S_RINSE) || (state_q == S_SPIN);
    // Pause only freezes the running phases; DONE keeps counting regardless.
    assign counting = (active && !pause) || (state_q == S_DONE);
    assign tick     = counting && (pre_q == PRE_MAX);

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        bal_d    = bal_q;
        mode_d   = mode_q;
        pre_d    = pre_q;
        nxt      = S_DONE;

        case (state_q)
            S_IDLE, S_ERR: begin
                if (state_q == S_ERR && abort) begin
                    state_d  = S_IDLE;
                    remain_d = 8'd0;
                    pre_d    = '0;
                end else if (start) begin
                    pre_d = '0;
                    if (bal_in >= cost_of(mode)) begin
                        bal_d    = bal_in - cost_of(mode);
                        mode_d   = mode;
                        nxt      = next_phase(S_IDLE, mode);
                        state_d  = nxt;
                        remain_d = dur_of(nxt, mode);
                    end else begin
                        bal_d    = bal_in;
                        state_d  = S_ERR;
                        remain_d = 8'd0;
                    end
                end
            end
            default: begin
                if (abort) begin
                    state_d  = S_IDLE;
                    remain_d = 8'd0;
                    pre_d    = '0;
                end else if (counting) begin
                    if (tick) begin
                        pre_d = '0;
                        if (remain_q > 8'd1) begin
                            remain_d = remain_q - 8'd1;
                        end else if (state_q == S_DONE) begin
                            state_d  = S_IDLE;
                            remain_d = 8'd0;
                        end else begin
                            nxt      = next_phase(state_q, mode_q);
                            state_d  = nxt;
                            remain_d = dur_of(nxt, mode_q);
                        end
                    end else begin
                        pre_d = pre_q + PW'(1);
                    end
                end
            end
        endcase
    end

    assign frz = pause && ((state_d == S_WASH) || (state_d == S_RINSE) || (state_d == S_SPIN));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            remain_q <= 8'd0;
            bal_q    <= 10'd0;
            mode_q   <= 2'd0;
            pre_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            motor    <= 1'b0;
            valve    <= 1'b0;
            drain    <= 1'b0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            bal_q    <= bal_d;
            mode_q   <= mode_d;
            pre_q    <= pre_d;
            busy     <= (state_d == S_WASH) || (state_d == S_RINSE) || (state_d == S_SPIN);
            done     <= (state_d == S_DONE);
            err      <= (state_d == S_ERR);
            motor    <= ((state_d == S_WASH) || (state_d == S_SPIN)) && !frz;
            valve    <= ((state_d == S_WASH) || (state_d == S_RINSE)) && !frz;
            drain    <= (state_d == S_SPIN) && !frz;
        end
    end

    assign phase   = state_q;
    assign remain  = remain_q;
    assign bal_out = bal_q;

endmodule
